counter_sequencer: RTL and testbench

//   Control front end for the 10-bit up-counter datapath on the MAX10 board.
//   - Generates a single-cycle count-enable tick from the 50 MHz clock, so the counter needs no derived clock.
//   - Turns the asynchronous KEY[1] button into a synchronised single-cycle load command carrying a latched SW value.
//   - Sequences run / idle / halt through a small FSM.

---
 rtl/counter_sequencer.sv | 164 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: count-enable tick divider, KEY[1] load-command path and run/idle/load/halt FSM
// for the MAX10 10-bit up-counter. Define COUNTER_SEQ_DEBOUNCE_EN to add a KEY[1] debounce filter.
module counter_sequencer #(
    parameter int TICK_DIV  = 10,
    parameter int TICK_W    = 4,
    parameter int WIDTH     = 10,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic             MAX10_CLK1_50,
    input  logic [1:0]       KEY,
    input  logic [WIDTH-1:0] SW,
    input  logic             run,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_val,
    output logic [1:0]       state,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic rst_n;
    logic key_s1;
    logic key_s2;
    logic filt;
    logic filt_prev;
    logic load_evt;

    logic [TICK_W-1:0] div;
    logic [TICK_W-1:0] div_d;
    logic              div_last;
    logic              at_max;
    logic              tick_due;

    logic             cnt_en_d;
    logic             cnt_load_d;
    logic             tc_d;
    logic [WIDTH-1:0] load_val_d;

    assign rst_n = KEY[0];

    // Two-flop synchroniser; idles at the released (high) level.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= KEY[1];
            key_s2 <= key_s1;
        end
    end

`ifdef COUNTER_SEQ_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // Filtered level only follows after DB_CYCLES consecutive clocks at the new level.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b1;
        end else if (key_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= key_s2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign filt = db_level;
`else
    logic [DB_W-1:0] db_cfg_unused;
    assign db_cfg_unused = DB_W'(DB_CYCLES);
    assign filt = key_s2;
`endif

    // Registered falling-edge detect: one load_evt per press, nothing on hold or release.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            filt_prev <= 1'b1;
            load_evt  <= 1'b0;
        end else begin
            filt_prev <= filt;
            load_evt  <= filt_prev & ~filt;
        end
    end

    assign div_last = (div == TICK_W'(TICK_DIV - 1));
    assign at_max   = (count == '1);
    assign tick_due = (cur_state == RUN) && run && div_last;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        if (load_evt) begin
            next_state = LOAD;
        end else begin
            case (cur_state)
                IDLE: if (run) next_state = RUN;
                RUN: begin
                    if (!run) begin
                        next_state = IDLE;
                    end else if (tick_due && (WRAP == 0) && at_max) begin
                        next_state = HALT;
                    end
                end
                LOAD:    next_state = run ? RUN : IDLE;
                HALT:    if (!run) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are computed from the coming state so every strobe leaves a flop.
    always_comb begin
        cnt_en_d   = tick_due && (next_state == RUN);
        cnt_load_d = (next_state == LOAD);
        tc_d       = (next_state == HALT);
        load_val_d = load_evt ? SW : load_val;
        div_d      = '0;
        if ((cur_state == RUN) && (next_state == RUN)) begin
            div_d = div_last ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            tc       <= 1'b0;
            load_val <= '0;
            div      <= '0;
        end else begin
            cnt_en   <= cnt_en_d;
            cnt_load <= cnt_load_d;
            tc       <= tc_d;
            load_val <= load_val_d;
            div      <= div_d;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a WRAP=1 and a WRAP=0 instance share stimulus and are checked every
// cycle against a cycle-level model, plus directed literal checks of the key timing scenarios.
`timescale 1ns/1ps
module tb_counter_sequencer;

    localparam int TD = 10;
    localparam int W  = 10;
`ifdef COUNTER_SEQ_DEBOUNCE_EN
    localparam int DB  = 16;
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic         clk = 1'b0;
    logic [1:0]   KEY = 2'b11;
    logic [W-1:0] sw = '0;
    logic [W-1:0] count = '0;
    logic         run = 1'b0;

    logic         cnt_en_w, cnt_load_w, tc_w;
    logic [W-1:0] load_val_w;
    logic [1:0]   state_w;
    logic         cnt_en_h, cnt_load_h, tc_h;
    logic [W-1:0] load_val_h;
    logic [1:0]   state_h;

    int pass_cnt = 0;
    int check_cnt = 0;

    always #10 clk = ~clk;

    counter_sequencer #(.TICK_DIV(TD), .TICK_W(4), .WIDTH(W), .WRAP(1)) dut_w (
        .MAX10_CLK1_50(clk), .KEY(KEY), .SW(sw), .run(run), .count(count),
        .cnt_en(cnt_en_w), .cnt_load(cnt_load_w), .load_val(load_val_w),
        .state(state_w), .tc(tc_w)
    );

    counter_sequencer #(.TICK_DIV(TD), .TICK_W(4), .WIDTH(W), .WRAP(0)) dut_h (
        .MAX10_CLK1_50(clk), .KEY(KEY), .SW(sw), .run(run), .count(count),
        .cnt_en(cnt_en_h), .cnt_load(cnt_load_h), .load_val(load_val_h),
        .state(state_h), .tc(tc_h)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic k1, input logic r, input logic [W-1:0] s,
                                 input logic [W-1:0] c);
        KEY[1] = k1;
        run    = r;
        sw     = s;
        count  = c;
    endtask

    // Model: key history gives the load event, run age gives tick positions (index 0: WRAP=1, 1: WRAP=0).
    logic [63:0]  kh;
    logic [63:0]  fh;
    logic         f_now;
    logic         m_evt;
    logic [1:0]   m_state [2];
    int           m_age [2];
    logic         m_en [2];
    logic [W-1:0] m_val [2];

    always @(posedge clk or negedge KEY[0]) begin
        if (!KEY[0]) begin
            kh = '1;
            fh = '1;
            for (int i = 0; i < 2; i++) begin
                m_state[i] = S_IDLE;
                m_age[i]   = 0;
                m_en[i]    = 1'b0;
                m_val[i]   = '0;
            end
        end else begin
`ifdef COUNTER_SEQ_DEBOUNCE_EN
            f_now = (kh[DB:1] == {DB{~fh[0]}}) ? ~fh[0] : fh[0];
`else
            f_now = kh[0];
`endif
            m_evt = !fh[1] && fh[2];
            kh = {kh[62:0], KEY[1]};
            fh = {fh[62:0], f_now};
            for (int i = 0; i < 2; i++) begin
                m_en[i] = 1'b0;
                if (m_evt) begin
                    m_state[i] = S_LOAD;
                    m_val[i]   = sw;
                end else begin
                    case (m_state[i])
                        S_IDLE: if (run) begin m_state[i] = S_RUN; m_age[i] = 0; end
                        S_LOAD: begin m_state[i] = run ? S_RUN : S_IDLE; m_age[i] = 0; end
                        S_RUN: begin
                            if (!run) begin
                                m_state[i] = S_IDLE;
                            end else if ((m_age[i] + 1) % TD == 0) begin
                                if (i == 1 && count == '1) begin
                                    m_state[i] = S_HALT;
                                end else begin
                                    m_en[i] = 1'b1;
                                    m_age[i]++;
                                end
                            end else begin
                                m_age[i]++;
                            end
                        end
                        default: if (!run) m_state[i] = S_IDLE;
                    endcase
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (KEY[0]) begin
            checkOutput("w.state", int'(state_w), int'(m_state[0]));
            checkOutput("w.cnt_en", int'(cnt_en_w), int'(m_en[0]));
            checkOutput("w.cnt_load", int'(cnt_load_w), int'(m_state[0] == S_LOAD));
            checkOutput("w.tc", int'(tc_w), int'(m_state[0] == S_HALT));
            if (m_state[0] == S_LOAD) checkOutput("w.load_val", int'(load_val_w), int'(m_val[0]));
            checkOutput("h.state", int'(state_h), int'(m_state[1]));
            checkOutput("h.cnt_en", int'(cnt_en_h), int'(m_en[1]));
            checkOutput("h.cnt_load", int'(cnt_load_h), int'(m_state[1] == S_LOAD));
            checkOutput("h.tc", int'(tc_h), int'(m_state[1] == S_HALT));
            if (m_state[1] == S_LOAD) checkOutput("h.load_val", int'(load_val_h), int'(m_val[1]));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses[$];
        int h_pulses;
        int n_load;
        int load_pos;
        int first_en;
        int seen;
        logic [W-1:0] lv;

        #1 KEY[0] = 1'b0;
        repeat (3) @(negedge clk);
        KEY[0] = 1'b1;
        @(negedge clk);
        checkOutput("reset.state", int'(state_w), 0);
        checkOutput("reset.cnt_en", int'(cnt_en_w), 0);
        checkOutput("reset.cnt_load", int'(cnt_load_w), 0);
        checkOutput("reset.tc", int'(tc_w), 0);
        checkOutput("reset.load_val", int'(load_val_w), 0);

        // Tick positions after run 0->1
        applyStimulus(1'b1, 1'b1, '0, '0);
        h_pulses = 0;
        for (int j = 0; j < 35; j++) begin
            @(negedge clk);
            if (cnt_en_w) pulses.push_back(j);
            if (cnt_en_h) h_pulses++;
        end
        checkOutput("tick.count", pulses.size(), 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput("tick.pos", (k < pulses.size()) ? pulses[k] : -1, 10 * (k + 1));
        end
        checkOutput("tick.count_h", h_pulses, 3);

        // Asynchronous reset in the middle of a cnt_en pulse
        seen = 0;
        for (int j = 0; j < 20 && seen == 0; j++) begin
            @(negedge clk);
            if (cnt_en_w) seen = 1;
        end
        checkOutput("arst.tick_seen", seen, 1);
        #3 KEY[0] = 1'b0;
        #1;
        checkOutput("arst.state", int'(state_w), 0);
        checkOutput("arst.cnt_en", int'(cnt_en_w), 0);
        checkOutput("arst.tc", int'(tc_w), 0);
        @(negedge clk);
        KEY[0] = 1'b1;

        // Held load button: exactly one load, divider restart
        applyStimulus(1'b1, 1'b1, 10'h2A5, '0);
        repeat (5) @(negedge clk);
        KEY[1] = 1'b0;
        n_load = 0; load_pos = -1; first_en = -1; lv = '0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (cnt_load_w) begin
                n_load++;
                load_pos = j;
                lv = load_val_w;
            end
            if (n_load > 0 && first_en < 0 && cnt_en_w) first_en = j;
        end
        checkOutput("load.count", n_load, 1);
        checkOutput("load.latency", load_pos, LAT);
        checkOutput("load.value", int'(lv), 'h2A5);
        checkOutput("load.first_tick", first_en, LAT + 11);
        KEY[1] = 1'b1;
        n_load = 0;
        for (int j = 0; j < LAT + 20; j++) begin
            @(negedge clk);
            if (cnt_load_w) n_load++;
        end
        checkOutput("release.no_load", n_load, 0);

        // WRAP=0 terminal count halts instead of ticking
        applyStimulus(1'b1, 1'b1, 10'h2A5, 10'h3FF);
        seen = 0; h_pulses = 0;
        for (int j = 0; j < 15 && seen == 0; j++) begin
            @(negedge clk);
            if (cnt_en_h) h_pulses++;
            if (state_h == S_HALT) seen = 1;
        end
        checkOutput("halt.state", int'(state_h), 3);
        checkOutput("halt.tc", int'(tc_h), 1);
        checkOutput("halt.no_tick", h_pulses, 0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("halt.exit_state", int'(state_h), 0);
        checkOutput("halt.exit_tc", int'(tc_h), 0);

        // Load from HALT with run=1
        run = 1'b1;
        seen = 0;
        for (int j = 0; j < 20 && seen == 0; j++) begin
            @(negedge clk);
            if (state_h == S_HALT) seen = 1;
        end
        checkOutput("halt2.reached", seen, 1);
        applyStimulus(1'b0, 1'b1, 10'h001, 10'h3FF);
        seen = 0;
        for (int j = 0; j < LAT + 5 && seen == 0; j++) begin
            @(negedge clk);
            if (cnt_load_h) seen = 1;
        end
        checkOutput("hload.seen", seen, 1);
        checkOutput("hload.value", int'(load_val_h), 1);
        checkOutput("hload.tc", int'(tc_h), 0);
        @(negedge clk);
        checkOutput("hload.next_state", int'(state_h), 1);
        checkOutput("hload.next_tc", int'(tc_h), 0);
        applyStimulus(1'b1, 1'b1, 10'h001, '0);
        repeat (LAT + 20) @(negedge clk);

`ifdef COUNTER_SEQ_DEBOUNCE_EN
        // Short bounce is filtered, long press loads after the debounce window
        KEY[1] = 1'b0;
        repeat (5) @(negedge clk);
        KEY[1] = 1'b1;
        n_load = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (cnt_load_w) n_load++;
        end
        checkOutput("db.short_press", n_load, 0);
        KEY[1] = 1'b0;
        load_pos = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (cnt_load_w) load_pos = j;
        end
        checkOutput("db.long_press", load_pos, 19);
        KEY[1] = 1'b1;
        repeat (40) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
